regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised register file with a per-register pending-write scoreboard, for the next generation of the 16-bit pipeline. It replaces the fixed two-read-port file. It provides NREAD combinational read ports with write-back bypass, plus a debug read port. Its scoreboard tracks registers whose results are still in flight, so the decoder can stall on true hazards instead of relying on fixed pipeline timing. It sits between decode (reads and issue) and execute/memory (write-back).

## Interface
- WIDTH, 16, data width
- NREGS, 16, number of registers, including the memory-address micro-op register(s)
- AW, 4, address width; NREGS <= 2**AW
- NREAD, 2, number of read ports
- RO_REG, 7, index whose writes are discarded; set to NREGS or more to disable
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NREAD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  NREAD  register at port i has a write outstanding
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  debug read data, same bypass rules as rd_data
- issue_valid  in  1  decoder issues an op that will write issue_addr
- issue_addr  in  AW  destination of the issued op
- issue_ready  out  1  issue can be accepted this cycle
- wb_valid  in  1  write-back strobe
- wb_addr  in  AW  write-back destination
- wb_data  in  WIDTH  write-back value
- outstanding  out  AW+1  count of pending bits set
- wb_err  out  1  sticky flag: write-back to a register that was not pending

## Operation
- State: reg array NREGS x WIDTH, pending vector NREGS, outstanding counter, wb_err.
- Reads are combinational.
  - rd_data[i] = wb_data when wb_valid, wb_addr==rd_addr[i], and wb_addr!=RO_REG; otherwise the array contents.
  - An address >= NREGS reads 0.
- rd_busy[i] = pending[rd_addr[i]], except it is forced to 0 when a same-cycle wb_valid targets that address. An out-of-range address gives busy=0.
- issue_ready = !pending[issue_addr], or 1 when a same-cycle wb_valid targets issue_addr.
  - Only one outstanding write per register is allowed.
- Issue accept = issue_valid && issue_ready.
  - Accept sets pending[issue_addr].
  - Exception: issue_addr == RO_REG or issue_addr >= NREGS is accepted with no state change.
- Write-back writes array[wb_addr] = wb_data and clears pending[wb_addr].
  - Writes to RO_REG or to addresses >= NREGS are ignored entirely, with no wb_err.
  - A write-back to a valid, writable, non-pending register still writes, and sets wb_err (sticky).
- Same-cycle issue and write-back to the same address: the write completes and pending stays set for the new op. Net change in outstanding is 0.
- outstanding changes by +1 per accepted pending-setting issue and -1 per write-back that clears a set bit. Both in the same cycle gives 0 change. The counter never wraps; max is NREGS.
- reset clears the array to 0, pending, outstanding and wb_err. Reset has priority over same-cycle issue and write-back.

## Timing
- Read latency is 0 cycles: bypass makes a write-back visible in the same cycle, and the array holds it from the next edge.
- Pending set by issue at edge N: rd_busy and issue_ready reflect it from cycle N+1.
- Pending clear by write-back: reflected combinationally in the same cycle through the bypass terms.
- Output values during and after reset, in the reset cycle's following state: rd_data=0, dbg_data=0, rd_busy=0, issue_ready=1, outstanding=0, wb_err=0.
- No combinational path from issue_valid to any output. issue_ready depends only on issue_addr, wb_valid, wb_addr and state.

## Test plan
- Reset, then write-back r3=0x1234 with no issue → wb_err=1. The next cycle rd_data[0] with addr 3 reads 0x1234; wb_err stays 1 until reset.
- Issue r2 at cycle 0 → cycle 1: rd_busy for addr 2 =1, issue_ready for r2 =0, outstanding=1. Write-back r2=0xBEEF at cycle 3 → same cycle rd_data=0xBEEF and busy=0; cycle 4 outstanding=0.
- While r5 is pending, drive issue r5 together with write-back r5=0x0042 → issue accepted and value written. Pending remains 1 and outstanding is unchanged at 1.
- Issue r7 then write-back r7=0xFFFF → issue_ready=1, pending not set, outstanding=0. Read of addr 7 returns 0 and wb_err=0.
- Issue r0..r15 on consecutive cycles, skipping r7 → outstanding reaches 15. Write-backs drain it to 0 and every written value reads back.
- Mid-sequence with 3 pending, assert reset during a write-back to r1=0x00AA → next cycle outstanding=0, r1 reads 0, wb_err=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard.
// Combinational reads with write-back bypass; decode stalls on pending bits.
module regfile_scoreboard #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int NREAD  = 2,
    parameter int RO_REG = 7
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREAD*AW-1:0]    i_rd_addr,
    output logic [NREAD*WIDTH-1:0] o_rd_data,
    output logic [NREAD-1:0]       o_rd_busy,
    input  logic [AW-1:0]          i_dbg_addr,
    output logic [WIDTH-1:0]       o_dbg_data,
    input  logic                   i_issue_valid,
    input  logic [AW-1:0]          i_issue_addr,
    output logic                   o_issue_ready,
    input  logic                   i_wb_valid,
    input  logic [AW-1:0]          i_wb_addr,
    input  logic [WIDTH-1:0]       i_wb_data,
    output logic [AW:0]            o_outstanding,
    output logic                   o_wb_err
);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [AW:0]      r_outstanding;
    logic             r_wb_err;

    logic             w_wb_ok;
    logic             w_wb_pend;
    logic             w_iss_pend;
    logic             w_iss_set;
    logic             w_wb_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && (32'(a) != RO_REG);
    endfunction

    function automatic logic pend_at(input logic [NREGS-1:0] p,
                                     input logic [AW-1:0]    a);
        logic v;
        v = 1'b0;
        for (int r = 0; r < NREGS; r++)
            if (32'(a) == r) v = p[r];
        return v;
    endfunction

    assign w_wb_ok    = i_wb_valid && writable(i_wb_addr);
    assign w_wb_pend  = pend_at(r_pending, i_wb_addr);
    assign w_iss_pend = pend_at(r_pending, i_issue_addr);

    // A same-cycle write-back frees the slot for the new op
    assign o_issue_ready = !w_iss_pend ||
                           (i_wb_valid && i_wb_addr == i_issue_addr);

    assign w_iss_set = i_issue_valid && o_issue_ready &&
                       writable(i_issue_addr);
    assign w_wb_clr  = w_wb_ok && w_wb_pend;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_set[r] = w_iss_set && (32'(i_issue_addr) == r);
            w_clr[r] = w_wb_ok && (32'(i_wb_addr) == r);
        end
    end

    always_comb begin
        o_rd_data  = '0;
        o_rd_busy  = '0;
        o_dbg_data = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (32'(i_rd_addr[p*AW +: AW]) == r) begin
                    o_rd_data[p*WIDTH +: WIDTH] =
                        (w_wb_ok && i_wb_addr == i_rd_addr[p*AW +: AW]) ?
                        i_wb_data : r_mem[r];
                    o_rd_busy[p] = r_pending[r] &&
                        !(i_wb_valid && i_wb_addr == i_rd_addr[p*AW +: AW]);
                end
            end
        end
        for (int r = 0; r < NREGS; r++)
            if (32'(i_dbg_addr) == r)
                o_dbg_data = (w_wb_ok && i_wb_addr == i_dbg_addr) ?
                             i_wb_data : r_mem[r];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NREGS; r++)
                r_mem[r] <= '0;
            r_pending     <= '0;
            r_outstanding <= '0;
            r_wb_err      <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (w_clr[r]) r_mem[r] <= i_wb_data;
            // Set after clear so a same-address issue keeps the bit
            r_pending     <= (r_pending & ~w_clr) | w_set;
            r_outstanding <= r_outstanding + (AW+1)'(w_iss_set)
                                           - (AW+1)'(w_wb_clr);
            if (w_wb_ok && !w_wb_pend) r_wb_err <= 1'b1;
        end
    end

    assign o_outstanding = r_outstanding;
    assign o_wb_err      = r_wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed plan plus random traffic
// checked each cycle against an array-based model.
module tb_regfile_scoreboard;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int RO = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*W-1:0]  rd_data;
    logic [NR-1:0]    rd_busy;
    logic [AW-1:0]    dbg_addr;
    logic [W-1:0]     dbg_data;
    logic             issue_valid;
    logic [AW-1:0]    issue_addr;
    logic             issue_ready;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [W-1:0]     wb_data;
    logic [AW:0]      outstanding;
    logic             wb_err;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_mem [N];
    bit           m_pend [N];
    bit           m_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .WIDTH(W), .NREGS(N), .AW(AW), .NREAD(NR), .RO_REG(RO)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_rd_addr(rd_addr),
        .o_rd_data(rd_data),
        .o_rd_busy(rd_busy),
        .i_dbg_addr(dbg_addr),
        .o_dbg_data(dbg_data),
        .i_issue_valid(issue_valid),
        .i_issue_addr(issue_addr),
        .o_issue_ready(issue_ready),
        .i_wb_valid(wb_valid),
        .i_wb_addr(wb_addr),
        .i_wb_data(wb_data),
        .o_outstanding(outstanding),
        .o_wb_err(wb_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_rd(input logic [AW-1:0] a);
        if (int'(a) >= N) return '0;
        if (wb_valid && wb_addr == a && int'(a) != RO) return wb_data;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(input logic [AW-1:0] a);
        if (int'(a) >= N) return 1'b0;
        return m_pend[a] && !(wb_valid && wb_addr == a);
    endfunction

    function automatic bit m_ready(input logic [AW-1:0] a);
        if (int'(a) >= N) return 1'b1;
        return !m_pend[a] || (wb_valid && wb_addr == a);
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    always @(posedge clk) begin : model_upd
        bit rdy;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            rdy = m_ready(issue_addr);
            if (wb_valid && int'(wb_addr) < N && int'(wb_addr) != RO) begin
                if (!m_pend[wb_addr]) m_err = 1'b1;
                m_mem[wb_addr]  = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (issue_valid && rdy && int'(issue_addr) < N &&
                int'(issue_addr) != RO)
                m_pend[issue_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("m_rd_data%0d", p), 32'(rd_data[p*W +: W]),
                32'(m_rd(rd_addr[p*AW +: AW])));
            chk($sformatf("m_rd_busy%0d", p), 32'(rd_busy[p]),
                32'(m_busy(rd_addr[p*AW +: AW])));
        end
        chk("m_dbg_data", 32'(dbg_data), 32'(m_rd(dbg_addr)));
        chk("m_issue_ready", 32'(issue_ready), 32'(m_ready(issue_addr)));
        chk("m_outstanding", 32'(outstanding), 32'(m_count()));
        chk("m_wb_err", 32'(wb_err), 32'(m_err));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int q[$];
        reset      = 1'b1;
        rd_addr    = '0;
        dbg_addr   = '0;
        issue_addr = '0;
        wb_addr    = '0;
        wb_data    = '0;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
        #2;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(rd_busy), 32'd0);

        // unsolicited write-back to r3
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        rd_addr = 8'h03;
        #2 chk("t1_bypass", 32'(rd_data[15:0]), 32'h1234);
        cyc(); idle();
        #2 chk("t1_rd", 32'(rd_data[15:0]), 32'h1234);
        chk("t1_err", 32'(wb_err), 32'd1);
        cyc();
        #2 chk("t1_err_sticky", 32'(wb_err), 32'd1);

        // issue r2, write back three cycles later
        issue_valid = 1'b1; issue_addr = 4'd2;
        cyc(); idle(); rd_addr = 8'h02;
        #2 chk("t2_busy", 32'(rd_busy[0]), 32'd1);
        chk("t2_ready", 32'(issue_ready), 32'd0);
        chk("t2_outst", 32'(outstanding), 32'd1);
        cyc();
        cyc();
        wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 16'hBEEF;
        #2 chk("t2_bypass", 32'(rd_data[15:0]), 32'hBEEF);
        chk("t2_busy_clr", 32'(rd_busy[0]), 32'd0);
        chk("t2_ready_wb", 32'(issue_ready), 32'd1);
        cyc(); idle();
        #2 chk("t2_outst0", 32'(outstanding), 32'd0);

        // same-cycle issue and write-back on pending r5
        issue_valid = 1'b1; issue_addr = 4'd5;
        cyc(); idle();
        issue_valid = 1'b1; issue_addr = 4'd5;
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h0042;
        #2 chk("t3_ready", 32'(issue_ready), 32'd1);
        cyc(); idle(); rd_addr = 8'h05;
        #2 chk("t3_busy", 32'(rd_busy[0]), 32'd1);
        chk("t3_outst", 32'(outstanding), 32'd1);
        chk("t3_rd", 32'(rd_data[15:0]), 32'h0042);
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 16'h0043;
        cyc(); idle();

        // read-only r7
        do_reset();
        issue_valid = 1'b1; issue_addr = 4'd7;
        #2 chk("t4_ready", 32'(issue_ready), 32'd1);
        cyc(); idle();
        #2 chk("t4_outst", 32'(outstanding), 32'd0);
        chk("t4_ready2", 32'(issue_ready), 32'd1);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 16'hFFFF;
        rd_addr = 8'h77;
        #2 chk("t4_nobypass", 32'(rd_data), 32'd0);
        cyc(); idle();
        #2 chk("t4_rd", 32'(rd_data), 32'd0);
        chk("t4_err", 32'(wb_err), 32'd0);

        // fill every writable register, then drain
        for (int r = 0; r < N; r++) begin
            if (r == RO) continue;
            issue_valid = 1'b1; issue_addr = 4'(r);
            cyc();
        end
        idle();
        #2 chk("t5_full", 32'(outstanding), 32'd15);
        for (int r = 0; r < N; r++) begin
            if (r == RO) continue;
            wb_valid = 1'b1; wb_addr = 4'(r); wb_data = 16'(16'hA000 + r * 16'h0111);
            cyc();
        end
        idle();
        #2 chk("t5_drained", 32'(outstanding), 32'd0);
        chk("t5_err", 32'(wb_err), 32'd0);
        for (int r = 0; r < N; r++) begin
            if (r == RO) continue;
            rd_addr = {4'(r), 4'(r)}; dbg_addr = 4'(r);
            #2 chk($sformatf("t5_rd%0d", r), 32'(rd_data[31:16]),
                   32'(16'hA000 + r * 16'h0111));
            cyc();
        end

        // reset in the middle of traffic
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1; issue_addr = 4'(r);
            cyc();
        end
        idle();
        #2 chk("t6_outst3", 32'(outstanding), 32'd3);
        reset = 1'b1;
        wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 16'h00AA;
        rd_addr = 8'h01;
        cyc(); idle(); reset = 1'b0;
        #2 chk("t6_outst0", 32'(outstanding), 32'd0);
        chk("t6_rd", 32'(rd_data[15:0]), 32'd0);
        chk("t6_err", 32'(wb_err), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cyc();
            reset       = ($urandom_range(0, 199) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = 4'($urandom_range(0, 15));
            wb_valid    = ($urandom_range(0, 2) != 0);
            wb_addr     = 4'($urandom_range(0, 15));
            q.delete();
            for (int i = 0; i < N; i++)
                if (m_pend[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 7) != 0)
                wb_addr = 4'(q[$urandom_range(0, q.size() - 1)]);
            wb_data  = 16'($urandom);
            rd_addr  = 8'($urandom);
            dbg_addr = 4'($urandom);
        end
        cyc();
        idle();
        reset = 1'b0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
